pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
Program-counter register with integrated next-PC selection for the processor fetch stage. It replaces the fixed 32-bit two-input PC select with a parametrised unit that:
- picks among sequential, branch, jump and jump-register targets by fixed priority;
- holds the PC on stall;
- buffers one redirect that arrives during a stall, and applies it when the stall releases.

Parameters:
WIDTH, 32, PC and target width in bits (minimum 3)
INC, 4, sequential increment added to pc each unstalled cycle
RESET_VECTOR, 32'h0000_0000, pc value on reset
EXC_VECTOR, 32'h0000_0080, misaligned-target handler address (used only with optional feature)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold pc this cycle
branch_taken  in  1  branch redirect request
branch_target  in  WIDTH  branch destination
jump  in  1  jump redirect request
jump_target  in  WIDTH  jump destination
jr  in  1  jump-register redirect request
jr_target  in  WIDTH  register destination
pc  out  WIDTH  current program counter (registered)
pc_plus_inc  out  WIDTH  combinational pc + INC, modulo 2^WIDTH
redirect_pending  out  1  buffered redirect waiting for stall release (registered)
misalign  out  1  misaligned-target flag (registered; tied 0 when feature off)

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous and active-low.
- Reset values (reset_n low, no clock edge needed):
  - pc = RESET_VECTOR
  - redirect_pending = 0
  - held target register = 0
  - misalign = 0
- Request and selection:
  - req = jr | jump | branch_taken.
  - sel_target priority: jr_target > jump_target > branch_target.
- State HELD_NONE (redirect_pending=0):
  - stall=0, req=1: pc <= sel_target.
  - stall=0, req=0: pc <= pc + INC.
  - stall=1, req=0: pc holds.
  - stall=1, req=1: pc holds; held <= sel_target; go to HELD_VALID.
- State HELD_VALID (redirect_pending=1):
  - stall=1: pc holds. Any new req is ignored (first redirect wins) and held is unchanged.
  - stall=0: pc <= held; go to HELD_NONE. Any req in that same cycle is discarded, because it belongs to the wrong path.
- Latency:
  - Redirect while unstalled takes effect at the next edge.
  - Buffered redirect takes effect at the first edge with stall=0.
- Arithmetic: pc + INC is truncated to WIDTH; pc wraps to 0 (e.g. 32'hFFFF_FFFC + 4 -> 0). No carry-out.
- Reset mid-stall with a pending redirect: pending is dropped and pc = RESET_VECTOR immediately.
- redirect_pending equals the state bit; there are no other states.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - Every target about to load into pc (sel_target when unstalled, or held on release) is checked.
  - If bits [1:0] are nonzero, pc <= EXC_VECTOR instead of the target.
  - misalign is set to 1 for exactly that one cycle, registered with the pc update; otherwise misalign is 0.
  - The check is done at load time, not at capture time, so held stores the raw target.
  - Sequential increments are never checked.
- Undefined: targets load unchanged and misalign is constant 0.

Test Plan:
- Reset and sequencing:
  - Stimulus: reset_n=0, then release with no requests for 3 cycles.
  - Response: pc=0x0 while in reset; then 0x4, 0x8, 0xC; pc_plus_inc always pc+4.
- Redirect priority:
  - Stimulus: at pc=0x10, assert jr/jump/branch_taken together (targets 0x100/0x200/0x300) for one cycle.
  - Response: pc=0x100, then 0x104. Repeat with only jump+branch -> pc=0x200.
- Stall capture, ignore and release:
  - Stimulus: at pc=0x20, stall=1 with branch_taken (target 0x400); next cycle jump (target 0x500) while still stalled; then drop stall with jump (target 0x600) asserted.
  - Response: pc holds 0x20 and redirect_pending=1 during the stall; at release pc=0x400, pending=0; next pc=0x404.
- Wrap-around:
  - Stimulus: jr to 0xFFFF_FFFC, then no requests.
  - Response: pc=0xFFFF_FFFC, then 0x0000_0000.
- Async reset while pending:
  - Stimulus: stall=1, branch to 0x700 captured; pulse reset_n low between clock edges.
  - Response: pc=0x0 and redirect_pending=0 immediately; after release and stall=0, pc=0x4 (no 0x700).
- With PC_ALIGN_CHECK_EN:
  - Stimulus: jr to 0x102.
  - Response: pc=0x80 and misalign=1 for one cycle; next pc=0x84, misalign=0.

Source files
------------

// File: rtl/pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_next_unit
//  Purpose  : Fetch-stage program counter with next-PC selection. Chooses
//             between sequential, branch, jump and jump-register targets by
//             fixed priority (jr > jump > branch). It holds the PC on stall.
//             It buffers the first redirect seen during a stall and applies
//             that redirect on the first unstalled edge.
//  Ports    : clk              - rising-edge clock
//             reset_n          - asynchronous active-low reset
//             stall            - hold pc this cycle
//             branch_taken     - branch redirect request  / branch_target
//             jump             - jump redirect request    / jump_target
//             jr               - jump-register request    / jr_target
//             pc               - current program counter (registered)
//             pc_plus_inc      - pc + INC, modulo 2^WIDTH (combinational)
//             redirect_pending - buffered redirect awaiting stall release
//             misalign         - misaligned-target flag (registered)
//  Options  : `define PC_ALIGN_CHECK_EN to redirect misaligned targets
//             (bits [1:0] != 0) to EXC_VECTOR and pulse misalign.
//             When it is undefined, misalign stays 0.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_next_unit #(
    parameter int unsigned       WIDTH        = 32,
    parameter int unsigned       INC          = 4,
    parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]  EXC_VECTOR   = WIDTH'(32'h0000_0080)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [WIDTH-1:0]  branch_target,
    input  logic              jump,
    input  logic [WIDTH-1:0]  jump_target,
    input  logic              jr,
    input  logic [WIDTH-1:0]  jr_target,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_plus_inc,
    output logic              redirect_pending,
    output logic              misalign
);

    localparam logic [WIDTH-1:0] c_INC        = WIDTH'(INC);
    localparam logic [0:0]       c_HELD_NONE  = 1'b0;
    localparam logic [0:0]       c_HELD_VALID = 1'b1;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic c_ALIGN_CHECK = 1'b1;
`else
    localparam logic c_ALIGN_CHECK = 1'b0;
`endif

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_held;
    logic [0:0]       r_state;
    logic             r_misalign;

    logic             w_req;
    logic [WIDTH-1:0] w_sel_target;
    logic             w_load;
    logic [WIDTH-1:0] w_load_target;
    logic             w_misaligned;
    logic [WIDTH-1:0] w_next_pc;
    logic [0:0]       w_next_state;
    logic [WIDTH-1:0] w_next_held;

    assign w_req = jr | jump | branch_taken;

    always_comb begin
        w_sel_target = branch_target;
        if (jr) begin
            w_sel_target = jr_target;
        end else if (jump) begin
            w_sel_target = jump_target;
        end
    end

    // A buffered redirect always wins at release. Any request in that same
    // cycle is from the wrong path, so it is dropped.
    assign w_load        = !stall && ((r_state == c_HELD_VALID) || w_req);
    assign w_load_target = (r_state == c_HELD_VALID) ? r_held : w_sel_target;

    // Alignment is checked when a target loads into pc, not when it is
    // captured, so r_held always keeps the raw target.
    assign w_misaligned  = c_ALIGN_CHECK && w_load && (w_load_target[1:0] != 2'b00);

    always_comb begin
        w_next_pc    = r_pc;
        w_next_state = r_state;
        w_next_held  = r_held;
        if (!stall) begin
            w_next_state = c_HELD_NONE;
            if (w_misaligned) begin
                w_next_pc = EXC_VECTOR;
            end else if (w_load) begin
                w_next_pc = w_load_target;
            end else begin
                w_next_pc = pc_plus_inc;
            end
        end else if ((r_state == c_HELD_NONE) && w_req) begin
            // The first redirect during a stall is kept. Later ones are ignored.
            w_next_state = c_HELD_VALID;
            w_next_held  = w_sel_target;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= RESET_VECTOR;
            r_held     <= '0;
            r_state    <= c_HELD_NONE;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_next_pc;
            r_held     <= w_next_held;
            r_state    <= w_next_state;
            r_misalign <= w_misaligned;
        end
    end

    assign pc               = r_pc;
    assign pc_plus_inc      = r_pc + c_INC;
    assign redirect_pending = (r_state == c_HELD_VALID);
    assign misalign         = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_pc_next_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_next_unit
//  Purpose  : Self-checking bench for pc_next_unit. It runs directed
//             scenarios and then randomized traffic. All results are
//             compared against a queue-based behavioural model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_next_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        jr;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        redirect_pending;
    logic        misalign;

    int checks = 0;
    int errors = 0;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit c_ALIGN = 1'b1;
`else
    localparam bit c_ALIGN = 1'b0;
`endif

    // Behavioural model: the pc, the redirect waiting for stall release
    // (held as a queue of at most one entry), and the misalign flag.
    bit [31:0] m_pc;
    bit [31:0] m_held[$];
    bit        m_mis;

    pc_next_unit #(
        .WIDTH        (32),
        .INC          (4),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0080)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .stall            (stall),
        .branch_taken     (branch_taken),
        .branch_target    (branch_target),
        .jump             (jump),
        .jump_target      (jump_target),
        .jr               (jr),
        .jr_target        (jr_target),
        .pc               (pc),
        .pc_plus_inc      (pc_plus_inc),
        .redirect_pending (redirect_pending),
        .misalign         (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc = 32'h0;
        m_held.delete();
        m_mis = 1'b0;
    endtask

    task automatic model_load(input bit [31:0] t);
        if (c_ALIGN && (t % 4 != 0)) begin
            m_pc  = 32'h80;
            m_mis = 1'b1;
        end else begin
            m_pc = t;
        end
    endtask

    task automatic model_step();
        bit        req;
        bit [31:0] sel;
        req = jr || jump || branch_taken;
        sel = jr ? jr_target : (jump ? jump_target : branch_target);
        m_mis = 1'b0;
        if (!stall) begin
            if (m_held.size() != 0) model_load(m_held.pop_front());
            else if (req)           model_load(sel);
            else                    m_pc = m_pc + 32'd4;
        end else if (req && m_held.size() == 0) begin
            m_held.push_back(sel);
        end
    endtask

    // This task applies one cycle of inputs. It waits for the edge, advances
    // the model, and then settles 1 time unit after the edge.
    task automatic cycle(input bit s, input bit b, input bit [31:0] bt,
                         input bit j, input bit [31:0] jt,
                         input bit r, input bit [31:0] rt);
        stall = s; branch_taken = b; branch_target = bt;
        jump = j; jump_target = jt; jr = r; jr_target = rt;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
        branch_target = '0; jump_target = '0; jr_target = '0;
        model_reset();
        #3;
        checks++;
        if (pc !== 32'h0 || redirect_pending !== 1'b0 || misalign !== 1'b0) begin
            errors++;
            $display("FAIL reset_state pc=%h pend=%b mis=%b required pc=0 pend=0 mis=0",
                     pc, redirect_pending, misalign);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            idle();
            checks++;
            if (pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL seq_pc pc=%h required %h", pc, 32'(4 * i));
            end
            checks++;
            if (pc_plus_inc !== 32'(4 * i + 4)) begin
                errors++;
                $display("FAIL seq_pc_plus_inc got=%h required %h", pc_plus_inc, 32'(4 * i + 4));
            end
        end
    endtask

    task automatic test_priority();
        idle();                                   // 0xC -> 0x10
        checks++;
        if (pc !== 32'h10) begin
            errors++;
            $display("FAIL prio_start pc=%h required 00000010", pc);
        end
        cycle(1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h100);
        checks++;
        if (pc !== 32'h100) begin
            errors++;
            $display("FAIL prio_jr pc=%h required 00000100", pc);
        end
        idle();
        checks++;
        if (pc !== 32'h104) begin
            errors++;
            $display("FAIL prio_after_jr pc=%h required 00000104", pc);
        end
        cycle(1'b0, 1'b1, 32'h300, 1'b1, 32'h200, 1'b0, 32'h100);
        checks++;
        if (pc !== 32'h200) begin
            errors++;
            $display("FAIL prio_jump pc=%h required 00000200", pc);
        end
        cycle(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'h300) begin
            errors++;
            $display("FAIL prio_branch pc=%h required 00000300", pc);
        end
    endtask

    task automatic test_stall_capture();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h20);
        cycle(1'b1, 1'b1, 32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'h20 || redirect_pending !== 1'b1) begin
            errors++;
            $display("FAIL stall_capture pc=%h pend=%b required 00000020/1", pc, redirect_pending);
        end
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'h500, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'h20 || redirect_pending !== 1'b1) begin
            errors++;
            $display("FAIL stall_ignore pc=%h pend=%b required 00000020/1", pc, redirect_pending);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h600, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'h400 || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL stall_release pc=%h pend=%b required 00000400/0", pc, redirect_pending);
        end
        idle();
        checks++;
        if (pc !== 32'h404) begin
            errors++;
            $display("FAIL stall_after pc=%h required 00000404", pc);
        end
        // A stall without any request holds pc.
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (pc !== 32'h404 || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold pc=%h pend=%b required 00000404/0", pc, redirect_pending);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        checks++;
        if (pc !== 32'hFFFF_FFFC || pc_plus_inc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_load pc=%h plus=%h required fffffffc/00000000", pc, pc_plus_inc);
        end
        idle();
        checks++;
        if (pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_inc pc=%h required 00000000", pc);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b1, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 32'h0);
        checks++;
        if (redirect_pending !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup pend=%b required 1", redirect_pending);
        end
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (pc !== 32'h0 || redirect_pending !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate pc=%h pend=%b required 00000000/0", pc, redirect_pending);
        end
        #1;
        reset_n = 1'b1;
        idle();
        checks++;
        if (pc !== 32'h4) begin
            errors++;
            $display("FAIL areset_after pc=%h required 00000004", pc);
        end
    endtask

    task automatic test_align();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h102);
        checks++;
        if (c_ALIGN) begin
            if (pc !== 32'h80 || misalign !== 1'b1) begin
                errors++;
                $display("FAIL align_trap pc=%h mis=%b required 00000080/1", pc, misalign);
            end
        end else begin
            if (pc !== 32'h102 || misalign !== 1'b0) begin
                errors++;
                $display("FAIL align_off pc=%h mis=%b required 00000102/0", pc, misalign);
            end
        end
        idle();
        checks++;
        if (pc !== m_pc || misalign !== 1'b0) begin
            errors++;
            $display("FAIL align_next pc=%h mis=%b required %h/0", pc, misalign, m_pc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit [31:0] bt, jt, rt;
            bt = $urandom; jt = $urandom; rt = $urandom;
            // Most targets are aligned so that long sequential runs also occur.
            if ($urandom_range(0, 3) != 0) begin
                bt[1:0] = 2'b00; jt[1:0] = 2'b00; rt[1:0] = 2'b00;
            end
            cycle($urandom_range(0, 9) < 4, $urandom_range(0, 4) == 0, bt,
                  $urandom_range(0, 5) == 0, jt, $urandom_range(0, 6) == 0, rt);
            checks++;
            if (pc !== m_pc) begin
                errors++;
                $display("FAIL rand_pc n=%0d pc=%h required %h", n, pc, m_pc);
            end
            checks++;
            if (pc_plus_inc !== m_pc + 32'd4) begin
                errors++;
                $display("FAIL rand_plus n=%0d got=%h required %h", n, pc_plus_inc, m_pc + 32'd4);
            end
            checks++;
            if (redirect_pending !== (m_held.size() != 0)) begin
                errors++;
                $display("FAIL rand_pend n=%0d got=%b required %b", n, redirect_pending, m_held.size() != 0);
            end
            checks++;
            if (misalign !== m_mis) begin
                errors++;
                $display("FAIL rand_mis n=%0d got=%b required %b", n, misalign, m_mis);
            end
        end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_stall_capture();
        test_wrap();
        test_async_reset();
        test_align();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
